// File: rtl/mwbram_stream_reader_pkg.sv
// rtl/mwbram_stream_reader_pkg.sv - shared width helpers and FSM encodings for the stream reader
package mwbram_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int in_word_data(input int a_width, input int b_width);
    return a_width / b_width;
  endfunction

  function automatic int port_a_depth(input int b_depth, input int elems_per_word);
    return b_depth / elems_per_word;
  endfunction

  function automatic int len_width(input int b_addr);
    return b_addr + 1;
  endfunction

endpackage

// File: rtl/mwbram_word_buffer.sv
// rtl/mwbram_word_buffer.sv - two-entry wide-word prefetch buffer with element select
module mwbram_word_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int ELEM_WIDTH = 8,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [SEL_W-1:0]      start_sel_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] push_word_i,
  input  logic                  enable_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [ELEM_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  logic [WORD_WIDTH-1:0] word0_q, word0_d;
  logic [WORD_WIDTH-1:0] word1_q, word1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  head_q, head_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  xfer;
  logic                  word_pop;
  logic                  tail;
  logic [WORD_WIDTH-1:0] head_word;

  // Output only moves on a transfer; pushes land in the tail slot, so a stall holds data.
  assign head_word = head_q ? word1_q : word0_q;
  assign valid_o   = enable_i && (cnt_q != 2'd0);
  assign data_o    = head_word[sel_q*ELEM_WIDTH +: ELEM_WIDTH];
  assign count_o   = cnt_q;
  assign xfer      = valid_o && ready_i;
  assign word_pop  = xfer && ((sel_q == {SEL_W{1'b1}}) || last_i);
  assign tail      = head_q ^ cnt_q[0];

  always_comb begin
    word0_d = word0_q;
    word1_d = word1_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    sel_d   = sel_q;
    if (start_i) begin
      cnt_d  = 2'd0;
      head_d = 1'b0;
      sel_d  = start_sel_i;
    end else begin
      if (push_i) begin
        if (tail) word1_d = push_word_i;
        else      word0_d = push_word_i;
      end
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, word_pop};
      if (word_pop) head_d = ~head_q;
      if (xfer)     sel_d  = sel_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word0_q <= '0;
      word1_q <= '0;
      cnt_q   <= 2'd0;
      head_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      word0_q <= word0_d;
      word1_q <= word1_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: rtl/mwbram_stream_reader.sv
// rtl/mwbram_stream_reader.sv - dual-port BRAM with byte-enabled wide port A and burst-streaming narrow port B
module mwbram_stream_reader
  import mwbram_stream_reader_pkg::*;
#(
  parameter int PORT_B_WIDTH = 8,
  parameter int PORT_B_DEPTH = 256,
  parameter int PORT_A_WIDTH = 32,
  parameter int PORT_B_ADDR  = log2_ceil(PORT_B_DEPTH),
  parameter int IN_WORD_DATA = in_word_data(PORT_A_WIDTH, PORT_B_WIDTH),
  parameter int PORT_A_DEPTH = port_a_depth(PORT_B_DEPTH, IN_WORD_DATA),
  parameter int PORT_A_ADDR  = log2_ceil(PORT_A_DEPTH),
  parameter int PORT_A_WE    = PORT_A_WIDTH / 8,
  parameter int LEN_WIDTH    = len_width(PORT_B_ADDR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [PORT_A_WE-1:0]    wea,
  input  logic [PORT_A_ADDR-1:0]  addra,
  input  logic [PORT_A_WIDTH-1:0] dina,
  output logic [PORT_A_WIDTH-1:0] douta,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [PORT_B_ADDR-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic [PORT_B_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    done
);

  localparam int SEL_W  = log2_ceil(IN_WORD_DATA);
  localparam int SPAN_W = LEN_WIDTH + 1;

  logic [PORT_A_WIDTH-1:0] mem_q [PORT_A_DEPTH];
  logic [PORT_A_WIDTH-1:0] douta_q;
  logic [PORT_A_WIDTH-1:0] b_rdata_q;
  logic                    pend_q;

  logic [1:0]              state_q, state_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [PORT_A_ADDR-1:0]  wa_q, wa_d;
  logic [SPAN_W-1:0]       words_q, words_d;

  logic                    accept;
  logic                    xfer;
  logic                    rd_issue;
  logic [1:0]              buf_cnt;
  logic [SPAN_W-1:0]       span;

  always_ff @(posedge clk) begin
    if (ena) begin
      for (int b = 0; b < PORT_A_WE; b++) begin
        if (wea[b]) mem_q[addra][b*8 +: 8] <= dina[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      douta_q <= '0;
    else if (ena) douta_q <= mem_q[addra];
  end

  always_ff @(posedge clk) begin
    if (rd_issue) b_rdata_q <= mem_q[wa_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= rd_issue;
  end

  assign douta     = douta_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign accept    = cmd_ready && cmd_valid;
  assign xfer      = m_tvalid && m_tready;
  assign m_tlast   = m_tvalid && (rem_q == LEN_WIDTH'(1));

  // Buffered words plus the one in flight never exceed the two holding slots.
  assign rd_issue = ((state_q == ST_FETCH) || (state_q == ST_STREAM)) && (words_q != '0) &&
                    ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && !pend_q));

  // Words touched by the burst: start offset plus length, rounded up to whole words.
  assign span = SPAN_W'(cmd_addr[SEL_W-1:0]) + SPAN_W'(cmd_len) + SPAN_W'(IN_WORD_DATA - 1);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wa_d    = wa_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rem_d   = cmd_len;
          wa_d    = cmd_addr[PORT_B_ADDR-1:SEL_W];
          words_d = span >> SEL_W;
          state_d = (cmd_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_STREAM;
      ST_STREAM: begin
        if (xfer) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rd_issue) begin
      wa_d    = wa_q + PORT_A_ADDR'(1);
      words_d = words_q - SPAN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      wa_q    <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wa_q    <= wa_d;
      words_q <= words_d;
    end
  end

  mwbram_word_buffer #(
    .WORD_WIDTH (PORT_A_WIDTH),
    .ELEM_WIDTH (PORT_B_WIDTH),
    .SEL_W      (SEL_W)
  ) u_word_buffer (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept),
    .start_sel_i (cmd_addr[SEL_W-1:0]),
    .push_i      (pend_q),
    .push_word_i (b_rdata_q),
    .enable_i    (state_q == ST_STREAM),
    .last_i      (rem_q == LEN_WIDTH'(1)),
    .ready_i     (m_tready),
    .valid_o     (m_tvalid),
    .data_o      (m_tdata),
    .count_o     (buf_cnt)
  );

endmodule

// File: doc/mwbram_stream_reader.md
# mwbram_stream_reader

Dual-port block RAM with a wide byte-enabled random-access port A (PS side) and a narrow port B that is a command-driven burst reader. Port B takes a start element address and a length, then streams narrow elements out over a valid/ready interface. It fetches each wide word once, handles unaligned starts and wrap-around, and absorbs backpressure without dropping or duplicating elements. It sits between PS-loaded parameter memories and the KAN compute datapath, and replaces per-element addressed reads with streaming bursts.

## Interface
- PORT_B_WIDTH, 8, narrow element width in bits
- PORT_B_DEPTH, 256, element count; power of 2
- PORT_B_ADDR, LOG2(PORT_B_DEPTH), element address width
- PORT_A_WIDTH, 32, wide word width; a multiple of 8 and a power-of-2 multiple of PORT_B_WIDTH
- IN_WORD_DATA, PORT_A_WIDTH/PORT_B_WIDTH, elements per word (at least 2)
- PORT_A_DEPTH, PORT_B_DEPTH/IN_WORD_DATA, word count
- PORT_A_ADDR, LOG2(PORT_A_DEPTH), word address width
- PORT_A_WE, PORT_A_WIDTH/8, byte-enable count
- LEN_WIDTH, PORT_B_ADDR+1, burst length width
- clk  in  1  single clock; every register samples on its rising edge
- rst  in  1  reset, asynchronous and active-high
- ena  in  1  port A enable
- wea  in  PORT_A_WE  per-byte write enable
- addra  in  PORT_A_ADDR  word address
- dina  in  PORT_A_WIDTH  write data
- douta  out  PORT_A_WIDTH  registered read data; read-first
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  PORT_B_ADDR  first element address
- cmd_len  in  LEN_WIDTH  element count, 0 to PORT_B_DEPTH
- m_tdata  out  PORT_B_WIDTH  element data
- m_tvalid  out  1  element valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  marks the final element of a burst
- busy  out  1  a burst is in progress
- done  out  1  one-cycle pulse when a burst completes

## Operation
- Storage is an array of PORT_A_DEPTH words of PORT_A_WIDTH bits.
- Element e lives in word e>>LOG2(IN_WORD_DATA), at bits [lsb*PORT_B_WIDTH +: PORT_B_WIDTH], where lsb is the low LOG2(IN_WORD_DATA) bits of e.
- Port A:
  - When ena is high, bytes selected by wea are written.
  - douta returns the pre-write contents one cycle later.
  - When ena is low, douta holds its value.
- FSM states:
  - IDLE: cmd_ready=1. A handshake (cmd_valid && cmd_ready) latches addr and len.
    - len==0 goes to DONE.
    - Otherwise goes to FETCH.
  - FETCH: issues the first word read, then goes to STREAM.
  - STREAM: emits elements in order. An element transfers on m_tvalid && m_tready. The element address increments modulo PORT_B_DEPTH, so the burst wraps 255→0.
    - The next word is prefetched into a second holding register while the current word drains.
    - No bubble at word boundaries or at wrap, provided m_tready stays high.
    - After the transfer with m_tlast, goes to DONE.
  - DONE: done=1 for one cycle, then goes to IDLE.
- Output rules:
  - m_tdata and m_tvalid hold stable while m_tvalid && !m_tready.
  - m_tlast is high exactly when the remaining count is 1.
  - busy is high in FETCH, STREAM and DONE.
- Port B never writes. Each word is read at most once per burst, except that a burst of PORT_B_DEPTH elements with an unaligned start rereads its first word at the end.
- Port A and port B collisions: port B sees the array contents at the edge where it issues the word read. A same-cycle port A write to that word is not visible to port B (read-first).
- Commands presented while busy are not accepted; cmd_valid is simply held.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, m_tvalid=0, m_tlast=0, m_tdata=0, douta=0; FSM in IDLE. Array contents are not reset.
- Reset asserted mid-burst aborts the burst immediately and asynchronously. No done pulse is produced. After reset is released the block is in IDLE.
- Burst latency, for a command accepted at edge k:
  - The first element is valid after edge k+2.
  - With m_tready held high, element n is valid after edge k+2+n.
  - done is high during the cycle after the m_tlast transfer.
  - cmd_ready returns 1 in the cycle after that.
- A len==0 command produces done in the cycle after acceptance and no beats.
- Port A read latency is one cycle.

## Structure
- Shared package holds:
  - the LOG2 macro;
  - FSM state encodings (IDLE, FETCH, STREAM, DONE);
  - the derived-width rules: IN_WORD_DATA, PORT_A_DEPTH, LEN_WIDTH.
- Sub-module: mwbram_word_buffer, a 2-entry wide-word prefetch buffer with element-select mux and valid/ready hold logic.
- The array is written as inferable true-dual-port BRAM: port A read/write, port B read-only, both registered.

## Test plan
- Fill words 0..63 with 0x03020100 + 0x04040404·i. Then issue addr=0, len=8 with m_tready=1 -> elements 0x00..0x07, one per cycle from edge k+2, m_tlast on 0x07, done pulses once.
- Unaligned start: addr=3, len=6 -> elements 0x03..0x08, no bubble between 0x03 and 0x04.
- Backpressure: m_tready pattern 1,0,0,1,0,1… on addr=10, len=12 -> exactly elements 0x0A..0x15, each once, with m_tdata stable while stalled.
- Wrap-around: addr=254, len=4 -> elements at addresses 254,255,0,1. Then len=0 -> no beats, done one cycle after accept.
- Collision: while a burst of addr=0, len=32 streams, write word 7 with wea=4'b0011, dina=0xFFFFFFFF, one cycle before the fetch of word 7 -> elements 28,29 read 0xFF,0xFF and elements 30,31 keep their original values. A write in the same cycle as the fetch -> old data.
- Reset mid-burst at element 5 of 16 -> m_tvalid=0, busy=0, cmd_ready=1 immediately; no done pulse; the next command streams correctly.
